// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time loader for the instruction memory. It takes a byte stream from a
// host/boot channel, packs every four bytes into one 32-bit instruction word
// and writes that word to the instruction memory. Word addresses start at 0
// and go up by one word (byte address +4) for each word written. The CPU is
// held (PCWrite gated) until the whole image has been written.
//
// Optional feature, macro IMEM_LOADER_CHECKSUM_EN:
//   After the last word, four more bytes are received as a checksum word.
//   These bytes are never written to memory. The checksum word is compared
//   with the mod-2^32 sum of all written words. On a mismatch o_checksum_err
//   goes high and stays high until the next accepted start or reset.
//
// Parameters:
//   ADDR_WIDTH      word-index width; memory depth is 2**ADDR_WIDTH words
//                   (must be <= 30)
//   BYTE_BIG_ENDIAN 1: first byte of a word -> [31:24]; 0: first byte -> [7:0]
//
// Ports:
//   i_clk           system clock, rising edge
//   i_reset         synchronous, active-high reset
//   i_start         one-cycle pulse that begins a load (sampled only in IDLE)
//   i_load_len      number of words to load, sampled together with i_start
//   i_byte_valid    i_byte_data holds a valid byte
//   i_byte_data     incoming byte
//   o_byte_ready    the loader accepts a byte this cycle
//   o_mem_we        instruction memory write enable
//   o_mem_addr      byte address of the word being written (word_idx << 2)
//   o_mem_wdata     assembled instruction word
//   o_busy          a load is in progress
//   o_hold_cpu      gates PCWrite low while high
//   o_done          one-cycle pulse when the load completes
//   o_checksum_err  checksum mismatch flag (IMEM_LOADER_CHECKSUM_EN only)
//
// States:
//   ST_IDLE  | waiting for i_start
//   ST_RECV  | collecting the 4 bytes of an instruction word
//   ST_WRITE | single-cycle memory write of the assembled word
//   ST_CHECK | collecting the 4-byte checksum word (checksum build only)
//   ST_DONE  | one-cycle completion pulse, then back to IDLE
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_WIDTH      = 8,
  parameter int BYTE_BIG_ENDIAN = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_load_len,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte_data,
  output logic                  o_byte_ready,
  output logic                  o_mem_we,
  output logic [31:0]           o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic                  o_busy,
  output logic                  o_hold_cpu,
  output logic                  o_done
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic                  o_checksum_err
`endif
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_CHECK = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
`endif

  // Memory depth in words; also the upper bound applied to i_load_len.
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_len;
  // One bit wider than the memory index so a full-depth load reaches
  // word_idx+1 == DEPTH without wrapping back to 0.
  logic [ADDR_WIDTH:0]   r_word_idx;
  logic [1:0]            r_byte_cnt;
  logic [31:0]           r_shift;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]           r_sum;
`endif

  logic [ADDR_WIDTH:0]   w_len_clamped;
  logic [ADDR_WIDTH:0]   w_idx_next;
  logic [31:0]           w_next_word;
  logic [31:0]           w_word_addr;
  logic                  w_take;

  assign w_len_clamped = (i_load_len > DEPTH) ? DEPTH : i_load_len;
  assign w_idx_next    = r_word_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign w_word_addr   = {{(30-ADDR_WIDTH){1'b0}}, r_word_idx[ADDR_WIDTH-1:0], 2'b00};
  assign w_take        = i_byte_valid && o_byte_ready;

  // Big-endian shifts bytes in from the bottom, so the first byte ends in
  // [31:24]. Little-endian shifts in from the top, so the first byte ends in [7:0].
  assign w_next_word = (BYTE_BIG_ENDIAN != 0) ? {r_shift[23:0], i_byte_data}
                                              : {i_byte_data, r_shift[31:8]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_len          <= '0;
      r_word_idx     <= '0;
      r_byte_cnt     <= '0;
      r_shift        <= '0;
      o_byte_ready   <= 1'b0;
      o_mem_we       <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_wdata    <= '0;
      o_busy         <= 1'b0;
      o_hold_cpu     <= 1'b0;
      o_done         <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum          <= '0;
      o_checksum_err <= 1'b0;
`endif
    end else begin
      o_mem_we <= 1'b0;
      o_done   <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_len      <= w_len_clamped;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum          <= '0;
            o_checksum_err <= 1'b0;
`endif
            if (w_len_clamped == '0) begin
              r_state <= ST_DONE;
              o_done  <= 1'b1;
            end else begin
              r_state      <= ST_RECV;
              o_byte_ready <= 1'b1;
              o_busy       <= 1'b1;
              o_hold_cpu   <= 1'b1;
            end
          end
        end

        ST_RECV: begin
          if (w_take) begin
            r_shift    <= w_next_word;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state      <= ST_WRITE;
              o_byte_ready <= 1'b0;
              o_mem_we     <= 1'b1;
              o_mem_addr   <= w_word_addr;
              o_mem_wdata  <= w_next_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_sum        <= r_sum + w_next_word;
`endif
            end
          end
        end

        ST_WRITE: begin
          r_word_idx <= w_idx_next;
          r_byte_cnt <= '0;
          if (w_idx_next == r_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state      <= ST_CHECK;
            o_byte_ready <= 1'b1;
`else
            r_state    <= ST_DONE;
            o_done     <= 1'b1;
            o_busy     <= 1'b0;
            o_hold_cpu <= 1'b0;
`endif
          end else begin
            r_state      <= ST_RECV;
            o_byte_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (w_take) begin
            r_shift    <= w_next_word;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state        <= ST_DONE;
              o_byte_ready   <= 1'b0;
              o_done         <= 1'b1;
              o_busy         <= 1'b0;
              o_hold_cpu     <= 1'b0;
              o_checksum_err <= (w_next_word != r_sum);
            end
          end
        end
`endif

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state      <= ST_IDLE;
          o_byte_ready <= 1'b0;
          o_busy       <= 1'b0;
          o_hold_cpu   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the instruction memory read path.
- Accepts a byte stream from a host/boot channel, assembles big-endian 32-bit instruction words, and drives the instruction memory write port with word-aligned byte addresses, incrementing from 0.
- Asserts a CPU hold while loading so the PC does not advance until the program image is complete.

Parameters:
- ADDR_WIDTH, 8, word-index width; memory depth = 2**ADDR_WIDTH words (256 by default).
- BYTE_BIG_ENDIAN, 1, 1: first received byte goes to [31:24]; 0: first byte goes to [7:0].

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE
- load_len  in  ADDR_WIDTH+1  number of words to load; sampled with start
- byte_valid  in  1  byte_data is valid
- byte_data  in  8  incoming byte
- byte_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write enable
- mem_addr  out  32  byte address = word_idx<<2 (same byte-address convention as the read port)
- mem_wdata  out  32  assembled instruction word
- busy  out  1  load in progress
- hold_cpu  out  1  gates PCWrite low while high
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0. Internal state: state=IDLE, word_idx=0, byte_cnt=0, shift reg=0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - byte_ready=0.
  - On start: latch len = min(load_len, 2**ADDR_WIDTH) and clear word_idx.
  - If len==0, go to DONE (no writes). Otherwise go to RECV.
- RECV:
  - byte_ready=1, busy=1, hold_cpu=1.
  - A byte is taken only when byte_valid && byte_ready; it is placed per BYTE_BIG_ENDIAN and byte_cnt increments.
  - When the 4th byte is taken (byte_cnt==3), go to WRITE.
  - byte_valid low stalls indefinitely with no timeout.
- WRITE:
  - Exactly one cycle with mem_we=1, mem_addr=word_idx<<2, mem_wdata=the assembled word; byte_ready=0.
  - Next cycle: word_idx+1, byte_cnt=0.
  - If word_idx+1==len, go to DONE; otherwise go to RECV.
- DONE: done=1 for one cycle, busy=0, hold_cpu=0 in the same cycle; then go to IDLE.
- Latency: minimum 5 cycles per word (4 accept cycles + 1 write). The first write appears 5 cycles after start with byte_valid held high.
- mem_addr and mem_wdata are held stable (registered) while mem_we=1. Outside WRITE their values are don't-care, but the bench shall only check them when mem_we=1.
- start while busy is ignored, and load_len is not re-sampled.
- Full-depth load (len=256): the last address is 0x3FC. word_idx must not wrap before DONE, and no write goes to address 0 after 0x3FC.
- reset mid-load:
  - Next cycle returns to IDLE with all outputs 0.
  - The partial word is discarded with no write.
  - Words already written remain in memory.
  - done is not pulsed.
- reset coincident with start: reset wins.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - Adds an output checksum_err (1 bit) and a CHECK state entered after the last WRITE.
  - In CHECK, 4 further bytes are received as a word, assembled per BYTE_BIG_ENDIAN, and never written to memory.
  - That word is compared with the mod-2^32 sum of all written words.
  - On mismatch, checksum_err=1, held until the next start or reset; otherwise it stays 0.
  - done pulses after CHECK.
  - When len==0, CHECK is skipped.
- Disabled: no checksum_err port, no CHECK state, and the behaviour is as above.

Test Plan:
- Reset, then start with load_len=2, bytes 00 00 00 13, 8C 01 00 04 with byte_valid held high -> writes (0x0, 0x00000013) then (0x4, 0x8C010004); done pulses 11 cycles after start; hold_cpu high throughout.
- load_len=1, byte_valid toggling 1,0,1,0 during RECV -> only valid&&ready beats are counted; single write (0x0, word) after the 4th accepted byte.
- load_len=0 -> no mem_we; done pulses the cycle after IDLE exit; busy never held more than 1 cycle.
- load_len=300 with an incrementing byte pattern -> exactly 256 writes; last mem_addr=0x3FC; no write to 0x0 after 0x3FC.
- reset asserted after 2 bytes of word 1 (load_len=3, word 0 already written) -> no further mem_we; done stays 0; a new start with load_len=1 rewrites 0x0.
- IMEM_LOADER_CHECKSUM_EN, load_len=2, words 0x1 and 0x2:
  - checksum bytes 00 00 00 03 -> checksum_err=0.
  - checksum bytes 00 00 00 04 -> checksum_err=1, held until the next start.
